// File: rtl/ofm_writer_if.sv
// Memory write bus used by ofm_writer.
//   wr_valid : write request (master -> slave)
//   wr_ready : slave accepts the write when high together with wr_valid
//   wr_addr  : word address of the write
//   wr_data  : word written
interface ofm_writer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/ofm_writer.sv
// Output feature-map writer: buffers pooled words from the conv/pool stage in
// a small FIFO and streams them to memory at consecutive addresses.
// Ports:
//   clk1, rst            : clock, asynchronous active-high reset
//   start                : one-cycle pulse that opens a frame (honoured in IDLE only)
//   data_in, in_valid    : pooled word stream, no upstream stall
//   end_pool             : upstream frame-complete pulse
//   wr (master)          : memory write bus (wr_valid/wr_ready/wr_addr/wr_data)
//   busy, done           : frame in progress / one-cycle frame-finished pulse
//   overflow             : sticky, a word was dropped or arrived outside COLLECT/IDLE
//   short_frame          : sticky, end_pool came before the full frame was seen
module ofm_writer #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           CO         = 16,
    parameter int unsigned           FINAL_SIZE = 6,
    parameter int unsigned           FIFO_DEPTH = 16,
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  in_valid,
    input  logic                  end_pool,
    ofm_writer_if.master          wr,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  short_frame
);

    localparam int unsigned TOTAL = CO * FINAL_SIZE * FINAL_SIZE;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      in_cnt;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic             empty;
    logic             full;
    logic             pop;
    logic             start_go;
    logic             push_req;
    logic             push;
    logic             frame_end;
    logic [CNT_W-1:0] in_cnt_nxt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    assign pop      = !empty && wr.wr_ready;
    assign start_go = (state == IDLE) && start;
    assign push_req = (state == COLLECT) && in_valid;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    assign in_cnt_nxt = in_cnt + CNT_W'(push);
    // The push coincident with end_pool is counted before judging short_frame.
    assign frame_end  = end_pool || (in_cnt_nxt == CNT_W'(TOTAL));

    // Write bus is a pure function of registered FIFO/address state.
    assign wr.wr_valid = !empty;
    assign wr.wr_data  = empty ? '0 : mem[rd_ptr[IDX_W-1:0]];
    assign wr.wr_addr  = out_addr;

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk1) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= data_in;
        end
    end

    // FIFO pointers, input count and write address.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_cnt   <= '0;
            out_addr <= '0;
        end else if (start_go) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_cnt   <= '0;
            out_addr <= BASE_ADDR;
        end else begin
            in_cnt <= in_cnt_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                out_addr <= out_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // Frame control FSM with registered status outputs.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= COLLECT;
                        busy        <= 1'b1;
                        overflow    <= 1'b0;
                        short_frame <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (push_req && !push) begin
                        overflow <= 1'b1;
                    end
                    if (frame_end) begin
                        state <= DRAIN;
                        if (end_pool && (in_cnt_nxt < CNT_W'(TOTAL))) begin
                            short_frame <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (in_valid) begin
                        overflow <= 1'b1;
                    end
                    if (empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (in_valid) begin
                        overflow <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
